// File: rtl/audio_frame_bridge.sv
// audio_frame_bridge: buffers upstream stereo frames in a small FIFO and plays
// them out one channel at a time on the codec's sample_end pulses. A frame is
// only ever started at a left-slot boundary, so left/right never get swapped.
// Optional capture path (define AUDIO_BRIDGE_RX_EN) packs audio_input back into
// stereo frames on a valid/ready stream.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; valid, once raised, holds with stable data until that edge, and
// ready may depend only on registered state.
module audio_frame_bridge #(
    parameter int DEPTH_LOG2 = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [15:0]           tx_left,
    input  logic [15:0]           tx_right,
    input  logic [1:0]            sample_end,
    output logic [15:0]           audio_output,
    input  logic [15:0]           audio_input,
    output logic [1:0]            channel_sel,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [15:0]           rx_left,
    output logic [15:0]           rx_right,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [CNT_W-1:0]      underrun_cnt,
    output logic [CNT_W-1:0]      overflow_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [31:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [31:0]            head;
    logic                   push;
    logic                   pop;
    logic                   frame_ok;
    logic                   frame_ok_nxt;
    logic [15:0]            out_nxt;
    logic                   underrun;

    // Full is judged on the registered level, so a full FIFO refuses even in a pop cycle.
    assign tx_ready    = (fifo_level != FULL_LEVEL);
    assign push        = tx_valid && tx_ready;
    assign head        = mem[rd_ptr];
    assign channel_sel = (state == IDLE) ? 2'b00 : 2'b11;

    // Frame storage; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {tx_left, tx_right};
        end
    end

    // FIFO pointers and level; push+pop together leave the level unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Playback state, output sample, frame_ok flag and saturating underrun count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            frame_ok     <= 1'b0;
            audio_output <= '0;
            underrun_cnt <= '0;
        end else begin
            state        <= state_nxt;
            frame_ok     <= frame_ok_nxt;
            audio_output <= out_nxt;
            if (underrun && (underrun_cnt != {CNT_W{1'b1}})) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
        end
    end

    // Slot sequencing; a double pulse is treated as a left-slot end only.
    always_comb begin
        state_nxt    = state;
        frame_ok_nxt = frame_ok;
        out_nxt      = audio_output;
        pop          = 1'b0;
        underrun     = 1'b0;
        case (state)
            IDLE: begin
                out_nxt = '0;
                if ((sample_end == 2'b01) && enable) begin
                    state_nxt = LEFT;
                end
            end
            LEFT: begin
                if (sample_end[1]) begin
                    if (!enable) begin
                        state_nxt = IDLE;
                        out_nxt   = '0;
                    end else begin
                        // Registered level: a push landing this very cycle is not seen.
                        if (fifo_level != '0) begin
                            out_nxt      = head[31:16];
                            frame_ok_nxt = 1'b1;
                        end else begin
                            out_nxt      = '0;
                            frame_ok_nxt = 1'b0;
                            underrun     = 1'b1;
                        end
                        state_nxt = RIGHT;
                    end
                end
            end
            RIGHT: begin
                if (sample_end == 2'b01) begin
                    // An underrun frame stays silent here even if data has since arrived.
                    out_nxt   = frame_ok ? head[15:0] : 16'h0000;
                    pop       = frame_ok;
                    state_nxt = LEFT;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef AUDIO_BRIDGE_RX_EN
    logic [15:0] rx_left_hold;
    logic        cap_left;
    logic        cap_frame;

    assign cap_left  = (state == LEFT) && sample_end[1];
    assign cap_frame = (state == RIGHT) && (sample_end == 2'b01);

    // Capture path: hold the left sample, then deliver or drop the whole frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_left_hold <= '0;
            rx_valid     <= 1'b0;
            rx_left      <= '0;
            rx_right     <= '0;
            overflow_cnt <= '0;
        end else begin
            if (cap_left) begin
                rx_left_hold <= audio_input;
            end
            if (cap_frame) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid <= 1'b1;
                    rx_left  <= rx_left_hold;
                    rx_right <= audio_input;
                end else if (overflow_cnt != {CNT_W{1'b1}}) begin
                    overflow_cnt <= overflow_cnt + 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
`else
    logic unused_rx;

    assign unused_rx    = ^{rx_ready, audio_input};
    assign rx_valid     = 1'b0;
    assign rx_left      = '0;
    assign rx_right     = '0;
    assign overflow_cnt = '0;
`endif

endmodule

// File: tb/tb_audio_frame_bridge.sv
// Bench for audio_frame_bridge: directed scenarios followed by random traffic,
// checked against a frame-queue reference model and an expected-sample queue.
module tb_audio_frame_bridge;

    localparam int DL    = 3;
    localparam int DEPTH = 1 << DL;
    localparam int CW    = 16;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [15:0]   tx_left = '0;
    logic [15:0]   tx_right = '0;
    logic [1:0]    sample_end = '0;
    logic [15:0]   audio_output;
    logic [15:0]   audio_input = '0;
    logic [1:0]    channel_sel;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [15:0]   rx_left;
    logic [15:0]   rx_right;
    logic [DL:0]   fifo_level;
    logic [CW-1:0] underrun_cnt;
    logic [CW-1:0] overflow_cnt;

    audio_frame_bridge #(.DEPTH_LOG2(DL), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_left(tx_left), .tx_right(tx_right),
        .sample_end(sample_end), .audio_output(audio_output), .audio_input(audio_input),
        .channel_sel(channel_sel), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_left(rx_left), .rx_right(rx_right), .fifo_level(fifo_level),
        .underrun_cnt(underrun_cnt), .overflow_cnt(overflow_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: frames waiting to play, playback position, counters.
    logic [31:0] m_q[$];
    bit          m_run;
    bit          m_want_left;
    bit          m_ok;
    logic [15:0] m_out;
    int          m_und;
    logic [15:0] m_hold;
    bit          m_rxv;
    logic [15:0] m_rxl;
    logic [15:0] m_rxr;
    int          m_ovf;

    // Scoreboard
    logic [15:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_run = 0; m_want_left = 0; m_ok = 0; m_out = '0; m_und = 0;
        m_hold = '0; m_rxv = 0; m_rxl = '0; m_rxr = '0; m_ovf = 0;
    endtask

    // Registered outputs against the model, sampled mid-cycle.
    task automatic check_state();
        chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        chk("tx_ready", 32'(tx_ready), 32'(m_q.size() < DEPTH));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(m_und));
        chk("channel_sel", 32'(channel_sel), m_run ? 32'd3 : 32'd0);
`ifdef AUDIO_BRIDGE_RX_EN
        chk("rx_valid", 32'(rx_valid), 32'(m_rxv));
        chk("rx_left", 32'(rx_left), 32'(m_rxl));
        chk("rx_right", 32'(rx_right), 32'(m_rxr));
        chk("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
`else
        chk("rx_valid", 32'(rx_valid), 32'd0);
        chk("overflow_cnt", 32'(overflow_cnt), 32'd0);
`endif
    endtask

    // Driver: one clock edge with the given inputs; model advances alongside.
    task automatic step(input bit v, input logic [15:0] l, input logic [15:0] r,
                        input logic [1:0] se, input bit en, input bit rr,
                        input logic [15:0] ai);
        bit          accept;
        bit          frame_in;
        bit          rx_taken;
        logic [31:0] hd;
        @(negedge clk);
        check_state();
        tx_valid = v; tx_left = l; tx_right = r; sample_end = se;
        enable = en; rx_ready = rr; audio_input = ai;
        accept   = v && (m_q.size() < DEPTH);
        rx_taken = m_rxv && rr;
        frame_in = 0;
        hd       = (m_q.size() > 0) ? m_q[0] : 32'h0;
        if (se != 2'b00) begin
            if (!m_run) begin
                m_out = '0;
                if (se == 2'b01 && en) begin
                    m_run = 1; m_want_left = 1;
                end
            end else if (m_want_left) begin
                if (se[1]) begin
                    m_hold = ai;
                    if (!en) begin
                        m_run = 0; m_out = '0;
                    end else begin
                        if (m_q.size() > 0) begin
                            m_out = hd[31:16]; m_ok = 1;
                        end else begin
                            m_out = '0; m_ok = 0;
                            if (m_und < CMAX) m_und++;
                        end
                        m_want_left = 0;
                    end
                end
            end else if (se == 2'b01) begin
                m_out = m_ok ? hd[15:0] : 16'h0;
                if (m_ok) void'(m_q.pop_front());
                m_want_left = 1;
                frame_in = 1;
            end
            exp_q.push_back(m_out);
        end
        if (frame_in) begin
            if (!m_rxv || rr) begin
                m_rxv = 1; m_rxl = m_hold; m_rxr = ai;
            end else if (m_ovf < CMAX) begin
                m_ovf++;
            end
        end else if (rx_taken) begin
            m_rxv = 0;
        end
        if (accept) m_q.push_back({l, r});
        @(posedge clk);
    endtask

    task automatic quiet(input int n, input bit en);
        for (int i = 0; i < n; i++) step(0, 16'h0, 16'h0, 2'b00, en, 0, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        tx_valid = 0; sample_end = 2'b00; rx_ready = 0; reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        model_reset();
    endtask

    // Monitor: every slot-end pulse produces one expected sample, visible after the edge.
    always @(posedge clk) begin
        if (reset_n && sample_end != 2'b00) begin
            #1;
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL audio_output: got %0h, expected nothing queued", audio_output);
            end else begin
                chk("audio_output", 32'(audio_output), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        chk("reset_audio_output", 32'(audio_output), 32'd0);
        chk("reset_rx_right", 32'(rx_right), 32'd0);

        // Single frame plays left then right and pops.
        step(1, 16'h1234, 16'hABCD, 2'b00, 1, 0, 16'h0);
        step(0, 16'h0, 16'h0, 2'b01, 1, 0, 16'h0);
        step(0, 16'h0, 16'h0, 2'b10, 1, 0, 16'h0);
        step(0, 16'h0, 16'h0, 2'b01, 1, 0, 16'h0);
        quiet(1, 1);

        // Empty FIFO: silent frame, underrun counted.
        step(0, 16'h0, 16'h0, 2'b10, 1, 0, 16'h0);
        step(0, 16'h0, 16'h0, 2'b01, 1, 0, 16'h0);

        // Push coinciding with left-slot end into empty FIFO: still an underrun,
        // right stays silent, the frame plays next time.
        step(1, 16'h5555, 16'h6666, 2'b10, 1, 0, 16'h0);
        step(0, 16'h0, 16'h0, 2'b01, 1, 0, 16'h0);
        step(0, 16'h0, 16'h0, 2'b10, 1, 0, 16'h0);
        step(0, 16'h0, 16'h0, 2'b01, 1, 0, 16'h0);

        // Fill to full; the ninth frame waits, a pop frees space one cycle later.
        for (int i = 0; i < DEPTH + 1; i++) step(1, 16'(16'h100 + i), 16'(16'h200 + i), 2'b00, 1, 0, 16'h0);
        step(1, 16'h0999, 16'h0888, 2'b10, 1, 0, 16'h0);
        step(1, 16'h0999, 16'h0888, 2'b01, 1, 0, 16'h0);
        step(1, 16'h0999, 16'h0888, 2'b00, 1, 0, 16'h0);
        quiet(1, 1);

        // Double pulse acts as a left-slot end only.
        step(0, 16'h0, 16'h0, 2'b11, 1, 0, 16'h0);
        step(0, 16'h0, 16'h0, 2'b01, 1, 0, 16'h0);

        // Drop enable in the right slot: right still plays, next left end idles.
        step(0, 16'h0, 16'h0, 2'b10, 1, 0, 16'h0);
        step(0, 16'h0, 16'h0, 2'b01, 0, 0, 16'h0);
        step(0, 16'h0, 16'h0, 2'b10, 0, 0, 16'h0);
        quiet(1, 0);

        // Capture: first frame held, second dropped while downstream stalls.
        step(0, 16'h0, 16'h0, 2'b01, 1, 0, 16'h0);
        step(0, 16'h0, 16'h0, 2'b10, 1, 0, 16'h1111);
        step(0, 16'h0, 16'h0, 2'b01, 1, 0, 16'h2222);
        step(0, 16'h0, 16'h0, 2'b10, 1, 0, 16'h3333);
        step(0, 16'h0, 16'h0, 2'b01, 1, 0, 16'h4444);
        step(0, 16'h0, 16'h0, 2'b00, 1, 1, 16'h0);
        quiet(1, 1);

        // Reset mid-frame with three frames buffered.
        for (int i = 0; i < 3; i++) step(1, 16'(16'h700 + i), 16'(16'h800 + i), 2'b00, 1, 0, 16'h0);
        step(0, 16'h0, 16'h0, 2'b10, 1, 0, 16'h0);
        do_reset();
        chk("rst_audio_output", 32'(audio_output), 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        quiet(1, 1);

        // Random traffic in two phases: sparse then dense upstream pushes.
        for (int i = 0; i < 3000; i++) begin
            int          r;
            logic [1:0]  se;
            bit          v;
            r  = $urandom_range(0, 9);
            se = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 :
                 ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b10;
            v  = (i < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            step(v, 16'($urandom), 16'($urandom), se, ($urandom_range(0, 29) != 0),
                 bit'($urandom_range(0, 1)), 16'($urandom));
        end
        quiet(2, 1);
        chk("exp_q_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
